// File: rtl/img_axi_stream_top.sv
// img_axi_stream_top: streams one preloaded image frame from an internal AXI4 RAM out of an AXI4-Stream master.
// Latency: first o_tvalid 3 cycles after rst rises; at most 2 idle cycles between bursts with i_tready=1.
// Backpressure: i_tready drives rready directly, so a stalled beat stays in the RAM's registered R stage.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   i_tready   stream sink ready
//   o_tdata    stream data (image word)
//   o_tvalid   stream data valid
//   o_tlast    high on the final word of the frame

// img_axi_ram: AXI4 slave over a word array that the environment preloads through mem.
// Latency: first R beat 2 cycles after the AR handshake, then one beat per cycle.
// Backpressure: a beat is held in the rdata register until rready; the next beat loads only as it leaves.
// Ports: AXI4 AW/W/B (accepted, answered SLVERR) and AR/R (INCR/FIXED bursts) channels.
module img_axi_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   i_awid,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic [7:0]            i_awlen,
  input  logic [2:0]            i_awsize,
  input  logic [1:0]            i_awburst,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                  i_wlast,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [ID_WIDTH-1:0]   o_bid,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  input  logic [ID_WIDTH-1:0]   i_arid,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  input  logic [7:0]            i_arlen,
  input  logic [2:0]            i_arsize,
  input  logic [1:0]            i_arburst,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  output logic [ID_WIDTH-1:0]   o_rid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_rlast,
  output logic                  o_rvalid,
  input  logic                  i_rready
);
  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  // Image store; contents survive reset and are written only by the environment.
  logic [DATA_WIDTH-1:0] mem [0:WORDS-1];

  logic                  r_rd_act;
  logic                  r_rd_fixed;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [7:0]            r_rd_cnt;
  logic [2:0]            r_rd_size;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic                  w_ar_hs;
  logic                  w_load;

  assign o_arready = !r_rd_act;
  assign w_ar_hs   = i_arvalid && o_arready;
  // Fetch the next word whenever the output register is empty or being drained this cycle.
  assign w_load    = r_rd_act && (!r_rvalid || i_rready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_act   <= 1'b0;
      r_rd_fixed <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_cnt   <= '0;
      r_rd_size  <= '0;
      r_rid      <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_rd_act   <= 1'b1;
        r_rd_fixed <= (i_arburst == 2'b00);
        r_rd_addr  <= i_araddr;
        r_rd_cnt   <= i_arlen;
        r_rd_size  <= i_arsize;
        r_rid      <= i_arid;
      end
      if (w_load) begin
        r_rdata  <= mem[r_rd_addr[ADDR_WIDTH-1:2]];
        r_rvalid <= 1'b1;
        r_rlast  <= (r_rd_cnt == 8'd0);
        // WRAP is not used by any master here and is handled as INCR.
        if (!r_rd_fixed) r_rd_addr <= r_rd_addr + (ADDR_WIDTH'(1) << r_rd_size);
        r_rd_cnt <= r_rd_cnt - 8'd1;
        if (r_rd_cnt == 8'd0) r_rd_act <= 1'b0;
      end else if (r_rvalid && i_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign o_rid   = r_rid;
  assign o_rdata = r_rdata;
  assign o_rresp = 2'b00;
  assign o_rlast = r_rlast;
  assign o_rvalid = r_rvalid;

  // Write path completes the protocol but does not modify the image; SLVERR tells a writer so.
  logic                r_wr_act;
  logic                r_bvalid;
  logic [ID_WIDTH-1:0] r_bid;

  assign o_awready = !r_wr_act && !r_bvalid;
  assign o_wready  = r_wr_act;
  assign o_bid     = r_bid;
  assign o_bresp   = 2'b10;
  assign o_bvalid  = r_bvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_act <= 1'b0;
      r_bvalid <= 1'b0;
      r_bid    <= '0;
    end else begin
      if (i_awvalid && o_awready) begin
        r_wr_act <= 1'b1;
        r_bid    <= i_awid;
      end
      if (i_wvalid && o_wready && i_wlast) begin
        r_wr_act <= 1'b0;
        r_bvalid <= 1'b1;
      end else if (r_bvalid && i_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  logic w_unused;
  assign w_unused = ^{i_awaddr, i_awlen, i_awsize, i_awburst, i_wdata, i_wstrb};
endmodule

module img_axi_stream_top #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int IMG_WORDS  = 1024,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tready,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  output logic                  o_tlast
);
  localparam int CW = $clog2(IMG_WORDS) + 1;
  // One extra address bit so the end-of-frame compare cannot wrap when the image fills the RAM.
  localparam logic [ADDR_WIDTH:0] BURST_BYTES = (ADDR_WIDTH + 1)'(BURST_LEN * STRB_WIDTH);
  localparam logic [ADDR_WIDTH:0] IMG_BYTES   = (ADDR_WIDTH + 1)'(IMG_WORDS * STRB_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH:0]   r_burst_base;
  logic [CW-1:0]         r_beat_cnt;
  logic                  w_arvalid, w_arready, w_rready;
  logic                  w_rvalid, w_rlast, w_beat_hs;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [ID_WIDTH-1:0]   w_rid, w_bid;
  logic [1:0]            w_rresp, w_bresp;
  logic                  w_awready, w_wready, w_bvalid;
  logic [ADDR_WIDTH:0]   w_base_next;

  assign w_beat_hs   = w_rvalid && w_rready;
  assign w_base_next = r_burst_base + BURST_BYTES;

  always_comb begin
    w_next    = r_state;
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_AR;
      S_AR: begin
        w_arvalid = 1'b1;
        if (w_arready) w_next = S_R;
      end
      S_R: begin
        w_rready = i_tready;
        if (w_beat_hs && w_rlast) w_next = (w_base_next >= IMG_BYTES) ? S_DONE : S_AR;
      end
      default: w_next = S_DONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_burst_base <= '0;
      r_beat_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_R && w_beat_hs) begin
        r_beat_cnt <= r_beat_cnt + CW'(1);
        if (w_rlast) r_burst_base <= w_base_next;
      end
    end
  end

  // Stream is a straight pass-through of the R channel while a burst is open.
  assign o_tvalid = (r_state == S_R) && w_rvalid;
  assign o_tdata  = o_tvalid ? w_rdata : '0;
  // Frame end comes from our own beat count, not from the per-burst rlast.
  assign o_tlast  = o_tvalid && (r_beat_cnt == CW'(IMG_WORDS - 1));

  img_axi_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ID_WIDTH  (ID_WIDTH)
  ) UUT (
    .clk      (clk),
    .rst      (rst),
    .i_awid   ('0),
    .i_awaddr ('0),
    .i_awlen  (8'd0),
    .i_awsize (3'd0),
    .i_awburst(2'd0),
    .i_awvalid(1'b0),
    .o_awready(w_awready),
    .i_wdata  ('0),
    .i_wstrb  ('0),
    .i_wlast  (1'b0),
    .i_wvalid (1'b0),
    .o_wready (w_wready),
    .o_bid    (w_bid),
    .o_bresp  (w_bresp),
    .o_bvalid (w_bvalid),
    .i_bready (1'b1),
    .i_arid   ('0),
    .i_araddr (r_burst_base[ADDR_WIDTH-1:0]),
    .i_arlen  (8'(BURST_LEN - 1)),
    .i_arsize (3'($clog2(STRB_WIDTH))),
    .i_arburst(2'b01),
    .i_arvalid(w_arvalid),
    .o_arready(w_arready),
    .o_rid    (w_rid),
    .o_rdata  (w_rdata),
    .o_rresp  (w_rresp),
    .o_rlast  (w_rlast),
    .o_rvalid (w_rvalid),
    .i_rready (w_rready)
  );

  logic w_unused;
  assign w_unused = ^{w_rid, w_rresp, w_bid, w_bresp, w_bvalid, w_awready, w_wready};
endmodule

// File: tb/tb_img_axi_stream_top.sv
module tb_img_axi_stream_top;
  localparam int IMG = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_tready = 1'b0;
  logic [31:0] o_tdata;
  logic        o_tvalid;
  logic        o_tlast;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  img_axi_stream_top dut (
    .clk     (clk),
    .rst     (rst),
    .i_tready(i_tready),
    .o_tdata (o_tdata),
    .o_tvalid(o_tvalid),
    .o_tlast (o_tlast)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 32'(o_tvalid), 32'd0);
    check({tag, "_tlast"},  32'(o_tlast),  32'd0);
    check({tag, "_tdata"},  o_tdata,       32'd0);
  endtask

  // Release reset away from the clock edge and measure cycles to the first o_tvalid.
  task automatic release_and_wait(input logic rdy);
    int lat = 0;
    i_tready = rdy;
    @(negedge clk);
    rst = 1'b1;
    while (!o_tvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("startup_latency_le5", 32'(lat <= 5), 32'd1);
  endtask

  // mode 0: ready always high; mode 1: ready low about one cycle in three.
  task automatic run_frame(input int mode, input int stop_after);
    int beats = 0;
    int cyc = 0;
    logic pv = 1'b0;
    logic [31:0] pd = '0;
    logic pl = 1'b0;
    logic [31:0] exp;
    while (beats < stop_after && cyc < 20000) begin
      if (pv) begin
        check("stall_tvalid", 32'(o_tvalid), 32'd1);
        check("stall_tdata", o_tdata, pd);
        check("stall_tlast", 32'(o_tlast), 32'(pl));
      end
      if (!o_tvalid) check("idle_tlast", 32'(o_tlast), 32'd0);
      i_tready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (o_tvalid && i_tready) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        check("beat_tdata", o_tdata, exp);
        check("beat_tlast", 32'(o_tlast), 32'(beats == IMG - 1));
        beats++;
      end
      pv = o_tvalid && !i_tready;
      pd = o_tdata;
      pl = o_tlast;
      @(posedge clk); #1;
      cyc++;
    end
    check("beat_count", 32'(beats), 32'(stop_after));
  endtask

  initial begin
    // Frame 1: ramp preload, ready held high.
    for (int i = 0; i < IMG; i++) begin
      dut.UUT.mem[i] = 32'(i);
      sb.push_back(32'(i));
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_and_wait(1'b1);
    run_frame(0, IMG);
    check("sb_drained_1", 32'(sb.size()), 32'd0);
    for (int c = 0; c < 200; c++) begin
      check("post_frame_tvalid", 32'(o_tvalid), 32'd0);
      check("post_frame_tlast", 32'(o_tlast), 32'd0);
      @(posedge clk); #1;
    end

    // Frame 2: hold ready low 50 cycles after first valid, then random ready.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset2");
    for (int i = 0; i < IMG; i++) sb.push_back(32'(i));
    release_and_wait(1'b0);
    for (int c = 0; c < 50; c++) begin
      check("hold_tvalid", 32'(o_tvalid), 32'd1);
      check("hold_tdata", o_tdata, 32'd0);
      check("hold_tlast", 32'(o_tlast), 32'd0);
      @(posedge clk); #1;
    end
    run_frame(1, IMG);
    check("sb_drained_2", 32'(sb.size()), 32'd0);

    // Frame 3: asynchronous reset after word 300, then a full restart.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < IMG; i++) sb.push_back(32'(i));
    release_and_wait(1'b1);
    run_frame(0, 301);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("async_reset_hold");
    sb.delete();
    for (int i = 0; i < IMG; i++) sb.push_back(32'(i));
    release_and_wait(1'b1);
    run_frame(1, IMG);
    check("sb_drained_3", 32'(sb.size()), 32'd0);

    // Frame 4: single marker word at index 4.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < IMG; i++) begin
      dut.UUT.mem[i] = (i == 4) ? 32'h1234_5678 : 32'd0;
      sb.push_back((i == 4) ? 32'h1234_5678 : 32'd0);
    end
    release_and_wait(1'b1);
    run_frame(1, IMG);
    check("sb_drained_4", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/img_axi_stream_top.md
Name: img_axi_stream_top

Overview:
- Top-level image streamer built from three parts:
  - an internal AXI4 slave RAM, instance UUT, holding a preloaded image;
  - an AXI4 read master that fetches the image in INCR bursts;
  - an AXI4-Stream master output port.
- After reset release it streams the whole image once, word by word, from address 0. It asserts last on the final word, then idles until the next reset.
- The RAM contents are loaded by the simulation environment through the array UUT.mem.

Parameters:
- DATA_WIDTH, 32, AXI and stream data width in bits; STRB_WIDTH = DATA_WIDTH/8.
- ADDR_WIDTH, 16, AXI byte-address width; the RAM holds 2^(ADDR_WIDTH-2) words.
- ID_WIDTH, 8, AXI ID width; the master always uses ID 0.
- IMG_WORDS, 1024, number of DATA_WIDTH words in one frame; must be a multiple of BURST_LEN.
- BURST_LEN, 16, beats per AXI read burst (arlen = BURST_LEN-1).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- _tready  input  1  stream sink ready.
- _tdata  output  DATA_WIDTH  stream data = image word.
- _tvalid  output  1  stream data valid.
- _tlast  output  1  marks the final word of the frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - _tvalid=0, _tlast=0, _tdata=0.
  - Internal arvalid=0, rready=0; address counter=0; FSM=IDLE.
  - RAM contents are not cleared by reset.
- Internal RAM (UUT):
  - Word array mem[0 : 2^(ADDR_WIDTH-2)-1] of DATA_WIDTH bits, indexed by byte address >> 2.
  - Full AXI4 slave; the write channels are tied off inactive by the top.
  - Read channel supports INCR bursts with arsize=log2(STRB_WIDTH).
  - Registered read data: rvalid follows arvalid&arready by at least 1 cycle.
  - rresp is always OKAY.
- Read master FSM:
  - IDLE -> AR on the first clock after reset release.
  - AR:
    - arvalid=1, araddr=burst_base, arlen=BURST_LEN-1, arburst=INCR, arsize=2 (32-bit).
    - araddr/arlen are held stable until arready.
    - On handshake -> R.
  - R:
    - rready = _tready, and _tvalid = rvalid, so the stream is a direct pass-through of the R channel.
    - _tdata = rdata.
    - Each beat transfers when rvalid & rready.
    - On rlast & handshake: burst_base += BURST_LEN*STRB_WIDTH.
    - If burst_base has reached IMG_WORDS*STRB_WIDTH -> DONE, else -> AR.
  - DONE: _tvalid=0 forever, until the next reset.
- _tlast:
  - Equals 1 exactly while the beat at word index IMG_WORDS-1 is presented.
  - Computed from the beat counter, independent of the AXI rlast.
- Backpressure:
  - While _tvalid=1 and _tready=0, _tdata and _tlast stay stable and no beat is lost.
  - _tvalid never drops before its handshake.
- Ordering: word i of the frame = mem[i], for i = 0..IMG_WORDS-1. No duplicates, no skips.
- Burst alignment: bursts are 64-byte aligned, so they never cross a 4 KB boundary.
- Inter-burst gap: at most 3 idle cycles between the last beat of one burst and the first beat of the next, with _tready=1.
- Startup latency: first _tvalid no later than 5 cycles after rst goes high.
- Reset mid-frame:
  - All outputs go to their reset values immediately.
  - After release the frame restarts from word 0.

Test Plan:
- Preload mem[i]=i, hold _tready=1, release reset → exactly 1024 beats with _tdata=0..1023 in order, _tlast=1 only on beat 1023, first _tvalid ≤5 cycles after reset release.
- Same preload, _tready toggled pseudo-randomly (e.g. 1 of every 3 cycles low) → identical 1024-word sequence; _tdata/_tlast stable whenever _tvalid&!_tready.
- Hold _tready=0 for 50 cycles after the first _tvalid → _tvalid stays 1 and _tdata stays 0 throughout; the stream resumes with 0,1,2… once _tready rises.
- After the frame completes, run 200 more cycles → _tvalid stays 0 and _tlast stays 0.
- Assert rst=0 asynchronously mid-frame (after word 300), then release → outputs are 0 during reset; the new frame starts again at _tdata=0 and is complete to 1023.
- Preload mem[4]=32'h12345678, other words 0 → beat index 4 carries 32'h12345678; all other beats carry 0.
